// File: rtl/mda_isa_defs.sv
// Shared definitions for the MDA ISA bus-cycle front-end.
// Contents: cycle FSM state encoding, default decode bases, strobe bit indices.
// No logic; imported by mda_isa_cycle.
package mda_isa_defs;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_HOLD = 2'd2
   } cyc_state_t;

   localparam logic [11:0] DEF_IO_BASE  = 12'h3B0;
   localparam logic [4:0]  DEF_MEM_BASE = 5'b10110;

   // Bit positions of the four ISA strobes in the packed strobe vector.
   localparam int STB_IOR  = 0;
   localparam int STB_IOW  = 1;
   localparam int STB_MEMR = 2;
   localparam int STB_MEMW = 3;

endpackage

// File: rtl/mda_sync.sv
// Multi-flop synchronizer for one asynchronous level into clk.
// Ports: clk, reset_l (async active-low), d_i (async level), q_o (synchronized level).
// Latency: STAGES clk; reset drives every stage to RST_VAL.
module mda_sync #(
   parameter int   STAGES  = 2,
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic reset_l,
   input  logic d_i,
   output logic q_o
);

   logic [STAGES-1:0] sync_q;

   always_ff @(posedge clk or negedge reset_l) begin
      if (!reset_l) begin
         sync_q <= {STAGES{RST_VAL}};
      end else begin
         sync_q <= {sync_q[STAGES-2:0], d_i};
      end
   end

   assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/mda_isa_cycle.sv
// ISA bus-cycle front-end for the MDA card: synchronizes the ISA strobes, decodes
// MDA I/O and memory cycles, and turns each accepted cycle into one request to the core.
// Ports: bus_* pad side (address, strobes, aen, data in/out, dir, IOCHRDY);
//        req_* / req_ack / rd_data core handshake; timeout pulse. All outputs registered.
module mda_isa_cycle
   import mda_isa_defs::*;
#(
   parameter logic [11:0] IO_BASE     = DEF_IO_BASE,
   parameter logic [4:0]  MEM_BASE    = DEF_MEM_BASE,
   parameter int          SYNC_STAGES = 2,
   parameter logic [7:0]  RDY_TIMEOUT = 8'd200
) (
   input  logic        clk,
   input  logic        reset_l,
   input  logic [19:0] bus_a,
   input  logic        bus_ior_l,
   input  logic        bus_iow_l,
   input  logic        bus_memr_l,
   input  logic        bus_memw_l,
   input  logic        bus_aen,
   input  logic [7:0]  bus_d_in,
   output logic [7:0]  bus_out,
   output logic        bus_dir,
   output logic        bus_rdy,
   output logic        req_io,
   output logic        req_mem,
   output logic        req_write,
   output logic [14:0] req_addr,
   output logic [7:0]  req_wdata,
   input  logic        req_ack,
   input  logic [7:0]  rd_data,
   output logic        timeout
);

   logic [3:0] strb_raw;
   logic [3:0] strb_s;

   assign strb_raw[STB_IOR]  = bus_ior_l;
   assign strb_raw[STB_IOW]  = bus_iow_l;
   assign strb_raw[STB_MEMR] = bus_memr_l;
   assign strb_raw[STB_MEMW] = bus_memw_l;

   for (genvar g = 0; g < 4; g++) begin : g_sync
      mda_sync #(
         .STAGES  (SYNC_STAGES),
         .RST_VAL (1'b1)
      ) u_sync (
         .clk     (clk),
         .reset_l (reset_l),
         .d_i     (strb_raw[g]),
         .q_o     (strb_s[g])
      );
   end

   cyc_state_t state_q, state_d;
   logic [3:0]  prev_q;
   logic [SYNC_STAGES-1:0] flush_q;
   logic        armed_q, armed_d;
   logic [1:0]  sel_q, sel_d;
   logic        wr_q, wr_d;
   logic        tmo_q, tmo_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        req_io_q, req_io_d;
   logic        req_mem_q, req_mem_d;
   logic        req_write_q, req_write_d;
   logic [14:0] req_addr_q, req_addr_d;
   logic [7:0]  req_wdata_q, req_wdata_d;
   logic [7:0]  bus_out_q, bus_out_d;
   logic        bus_dir_q, bus_dir_d;
   logic        bus_rdy_q, bus_rdy_d;
   logic        timeout_q, timeout_d;

   // Strobes are active low: a new cycle is a 1 -> 0 step of the synchronized level.
   logic [3:0] fall;
   logic       one_new, io_hit, mem_hit, accept, flushed;

   assign fall    = prev_q & ~strb_s;
   assign one_new = (fall != 4'd0) && ((fall & (fall - 4'd1)) == 4'd0);
   assign io_hit  = (fall[STB_IOR] | fall[STB_IOW]) & ~bus_aen &
                    (bus_a[11:4] == IO_BASE[11:4]);
   assign mem_hit = (fall[STB_MEMR] | fall[STB_MEMW]) & (bus_a[19:15] == MEM_BASE);
   assign accept  = armed_q & one_new & (io_hit | mem_hit) & (state_q == ST_IDLE);

   // The synchronizers come out of reset reading "high" regardless of the pads, so
   // all-high is only trusted once the reset values have been flushed through them.
   // Otherwise a strobe held low across reset would look like a fresh edge.
   assign flushed = flush_q[SYNC_STAGES-1];
   assign armed_d = armed_q | (flushed & (&strb_s));

   always_comb begin
      state_d     = state_q;
      sel_d       = sel_q;
      wr_d        = wr_q;
      tmo_d       = tmo_q;
      cnt_d       = cnt_q;
      req_io_d    = req_io_q;
      req_mem_d   = req_mem_q;
      req_write_d = req_write_q;
      req_addr_d  = req_addr_q;
      req_wdata_d = req_wdata_q;
      bus_out_d   = bus_out_q;
      timeout_d   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            bus_out_d = 8'hFF;
            if (accept) begin
               state_d     = ST_REQ;
               if (fall[STB_IOR])       sel_d = 2'(STB_IOR);
               else if (fall[STB_IOW])  sel_d = 2'(STB_IOW);
               else if (fall[STB_MEMR]) sel_d = 2'(STB_MEMR);
               else                     sel_d = 2'(STB_MEMW);
               wr_d        = fall[STB_IOW] | fall[STB_MEMW];
               tmo_d       = 1'b0;
               cnt_d       = 8'd0;
               req_io_d    = io_hit;
               req_mem_d   = mem_hit;
               req_write_d = fall[STB_IOW] | fall[STB_MEMW];
               req_addr_d  = io_hit ? {11'd0, bus_a[3:0]} : bus_a[14:0];
               req_wdata_d = bus_d_in;
            end
         end
         ST_REQ: begin
            if (req_ack) begin
               state_d     = ST_HOLD;
               bus_out_d   = wr_q ? 8'hFF : rd_data;
               req_io_d    = 1'b0;
               req_mem_d   = 1'b0;
               req_write_d = 1'b0;
            end else if (cnt_q == (RDY_TIMEOUT - 8'd1)) begin
               // Release the ISA bus but leave the request up; the core still owes an ack.
               state_d   = ST_HOLD;
               bus_out_d = 8'hFF;
               timeout_d = 1'b1;
               tmo_d     = 1'b1;
            end else if (cnt_q != 8'hFF) begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         ST_HOLD: begin
            // Only a timed-out cycle can still have a request outstanding here; its
            // late ack just retires the request.
            if (req_ack) begin
               req_io_d    = 1'b0;
               req_mem_d   = 1'b0;
               req_write_d = 1'b0;
            end
            if (strb_s[sel_q] && (!(req_io_q | req_mem_q) || req_ack)) begin
               state_d   = ST_IDLE;
               bus_out_d = 8'hFF;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      bus_rdy_d = (state_d != ST_REQ);
      bus_dir_d = (state_d != ST_IDLE) & ~wr_d & ~strb_s[sel_d];
   end

   always_ff @(posedge clk or negedge reset_l) begin
      if (!reset_l) begin
         state_q     <= ST_IDLE;
         prev_q      <= 4'hF;
         flush_q     <= '0;
         armed_q     <= 1'b0;
         sel_q       <= 2'd0;
         wr_q        <= 1'b0;
         tmo_q       <= 1'b0;
         cnt_q       <= 8'd0;
         req_io_q    <= 1'b0;
         req_mem_q   <= 1'b0;
         req_write_q <= 1'b0;
         req_addr_q  <= 15'd0;
         req_wdata_q <= 8'd0;
         bus_out_q   <= 8'hFF;
         bus_dir_q   <= 1'b0;
         bus_rdy_q   <= 1'b1;
         timeout_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         prev_q      <= strb_s;
         flush_q     <= {flush_q[SYNC_STAGES-2:0], 1'b1};
         armed_q     <= armed_d;
         sel_q       <= sel_d;
         wr_q        <= wr_d;
         tmo_q       <= tmo_d;
         cnt_q       <= cnt_d;
         req_io_q    <= req_io_d;
         req_mem_q   <= req_mem_d;
         req_write_q <= req_write_d;
         req_addr_q  <= req_addr_d;
         req_wdata_q <= req_wdata_d;
         bus_out_q   <= bus_out_d;
         bus_dir_q   <= bus_dir_d;
         bus_rdy_q   <= bus_rdy_d;
         timeout_q   <= timeout_d;
      end
   end

   assign bus_out   = bus_out_q;
   assign bus_dir   = bus_dir_q;
   assign bus_rdy   = bus_rdy_q;
   assign req_io    = req_io_q;
   assign req_mem   = req_mem_q;
   assign req_write = req_write_q;
   assign req_addr  = req_addr_q;
   assign req_wdata = req_wdata_q;
   assign timeout   = timeout_q;

endmodule

// File: tb/tb_mda_isa_cycle.sv
// Testbench for mda_isa_cycle: directed bus cycles plus randomized cycles whose
// expected request/handshake behaviour is derived from the address-decode and
// timing rules of the block. Prints one summary line.
module tb_mda_isa_cycle;

   logic        clk;
   logic        reset_l;
   logic [19:0] bus_a;
   logic        bus_ior_l, bus_iow_l, bus_memr_l, bus_memw_l;
   logic        bus_aen;
   logic [7:0]  bus_d_in;
   logic [7:0]  bus_out;
   logic        bus_dir, bus_rdy;
   logic        req_io, req_mem, req_write;
   logic [14:0] req_addr;
   logic [7:0]  req_wdata;
   logic        req_ack;
   logic [7:0]  rd_data;
   logic        timeout;

   int vectors;
   int miscompares;

   mda_isa_cycle dut (
      .clk        (clk),
      .reset_l    (reset_l),
      .bus_a      (bus_a),
      .bus_ior_l  (bus_ior_l),
      .bus_iow_l  (bus_iow_l),
      .bus_memr_l (bus_memr_l),
      .bus_memw_l (bus_memw_l),
      .bus_aen    (bus_aen),
      .bus_d_in   (bus_d_in),
      .bus_out    (bus_out),
      .bus_dir    (bus_dir),
      .bus_rdy    (bus_rdy),
      .req_io     (req_io),
      .req_mem    (req_mem),
      .req_write  (req_write),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .req_ack    (req_ack),
      .rd_data    (rd_data),
      .timeout    (timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_strb(input int idx, input logic v);
      case (idx)
         0: bus_ior_l  = v;
         1: bus_iow_l  = v;
         2: bus_memr_l = v;
         default: bus_memw_l = v;
      endcase
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_rdy"}, 32'(bus_rdy), 1);
      check({tag, "_dir"}, 32'(bus_dir), 0);
      check({tag, "_out"}, 32'(bus_out), 32'hFF);
      check({tag, "_req"}, 32'({req_io, req_mem}), 0);
   endtask

   // One complete ISA cycle; s: 0=IOR 1=IOW 2=MEMR 3=MEMW.
   task automatic run_cycle(input string tag, input int s, input logic [19:0] a,
                            input logic aen, input logic [7:0] d, input int dly,
                            input logic [7:0] rd);
      logic        io, wr, acc;
      logic [14:0] ea;
      io  = (s < 2);
      wr  = (s == 1) || (s == 3);
      acc = io ? (!aen && (a[11:4] == 8'h3B)) : (a[19:15] == 5'b10110);
      ea  = io ? {11'd0, a[3:0]} : a[14:0];
      bus_a = a; bus_aen = aen; bus_d_in = d;
      tick();
      set_strb(s, 1'b0);
      tick(); tick();
      check({tag, "_early"}, 32'({req_io, req_mem}), 0);
      tick();
      if (acc) begin
         check({tag, "_io"},  32'(req_io), 32'(io));
         check({tag, "_mem"}, 32'(req_mem), 32'(!io));
         check({tag, "_wr"},  32'(req_write), 32'(wr));
         check({tag, "_addr"}, 32'(req_addr), 32'(ea));
         if (wr) check({tag, "_wdata"}, 32'(req_wdata), 32'(d));
         check({tag, "_rdy0"}, 32'(bus_rdy), 0);
         check({tag, "_dir"}, 32'(bus_dir), 32'(!wr));
         repeat (dly) tick();
         check({tag, "_wait"}, 32'(bus_rdy), 0);
         req_ack = 1'b1; rd_data = rd;
         tick();
         req_ack = 1'b0;
         check({tag, "_rdy1"}, 32'(bus_rdy), 1);
         check({tag, "_out"}, 32'(bus_out), wr ? 32'hFF : 32'(rd));
         check({tag, "_clr"}, 32'({req_io, req_mem, req_write}), 0);
         set_strb(s, 1'b1);
         tick(); tick();
         check({tag, "_dirhold"}, 32'(bus_dir), 32'(!wr));
         tick();
         check_idle({tag, "_end"});
      end else begin
         check({tag, "_noreq"}, 32'({req_io, req_mem}), 0);
         check({tag, "_rdyhi"}, 32'(bus_rdy), 1);
         check({tag, "_nodir"}, 32'(bus_dir), 0);
         set_strb(s, 1'b1);
         tick(); tick(); tick();
      end
      bus_aen = 1'b0;
   endtask

   initial begin
      vectors = 0; miscompares = 0;
      reset_l = 1'b0;
      bus_a = 20'd0; bus_aen = 1'b0; bus_d_in = 8'd0;
      bus_ior_l = 1'b1; bus_iow_l = 1'b1; bus_memr_l = 1'b1; bus_memw_l = 1'b1;
      req_ack = 1'b0; rd_data = 8'd0;
      tick(); tick();
      check_idle("reset");
      check("reset_tmo", 32'(timeout), 0);
      check("reset_addr", 32'(req_addr), 0);
      check("reset_wdata", 32'(req_wdata), 0);
      check("reset_wr", 32'(req_write), 0);
      #3 reset_l = 1'b1;
      repeat (4) tick();

      // Directed cycles from the basic behaviour list.
      run_cycle("iow", 1, 20'h003B4, 1'b0, 8'h0C, 1, 8'h00);
      run_cycle("memr", 2, 20'hB0123, 1'b0, 8'h00, 0, 8'h41);
      run_cycle("io3d4", 0, 20'h003D4, 1'b0, 8'h00, 0, 8'h00);
      run_cycle("memb8", 2, 20'hB8000, 1'b0, 8'h00, 0, 8'h00);
      run_cycle("aen", 0, 20'h003B0, 1'b1, 8'h00, 0, 8'h00);
      run_cycle("memw", 3, 20'hB7FFF, 1'b0, 8'hA5, 3, 8'h00);

      // Timeout: read never acked until well after the wait-state limit.
      bus_a = 20'hB0010; tick();
      bus_memr_l = 1'b0;
      repeat (3) tick();
      check("to_req", 32'(req_mem), 1);
      repeat (199) tick();
      check("to_before_rdy", 32'(bus_rdy), 0);
      check("to_before_pulse", 32'(timeout), 0);
      tick();
      check("to_rdy", 32'(bus_rdy), 1);
      check("to_pulse", 32'(timeout), 1);
      check("to_out", 32'(bus_out), 32'hFF);
      check("to_reqheld", 32'(req_mem), 1);
      check("to_dir", 32'(bus_dir), 1);
      tick();
      check("to_pulse_off", 32'(timeout), 0);
      req_ack = 1'b1; rd_data = 8'h55;
      tick();
      req_ack = 1'b0;
      check("to_late_out", 32'(bus_out), 32'hFF);
      check("to_late_clr", 32'(req_mem), 0);
      bus_memr_l = 1'b1;
      repeat (3) tick();
      check_idle("to_end");

      // Aborted read: strobe released while the request is outstanding.
      bus_a = 20'h003B2; tick();
      bus_ior_l = 1'b0;
      repeat (3) tick();
      check("ab_req", 32'(req_io), 1);
      bus_ior_l = 1'b1;
      repeat (4) tick();
      check("ab_stillwait", 32'(bus_rdy), 0);
      check("ab_dir_off", 32'(bus_dir), 0);
      req_ack = 1'b1; rd_data = 8'h5A;
      tick();
      req_ack = 1'b0;
      check("ab_hold_out", 32'(bus_out), 32'h5A);
      check("ab_rdy", 32'(bus_rdy), 1);
      tick();
      check("ab_idle_out", 32'(bus_out), 32'hFF);
      run_cycle("ab_next", 0, 20'h003B7, 1'b0, 8'h00, 2, 8'h3C);

      // Reset asserted during REQ with the strobe held low across it.
      bus_a = 20'h003B5; tick();
      bus_ior_l = 1'b0;
      repeat (3) tick();
      check("rs_req", 32'(req_io), 1);
      reset_l = 1'b0;
      #2;
      check("rs_now_req", 32'(req_io), 0);
      check("rs_now_rdy", 32'(bus_rdy), 1);
      check("rs_now_out", 32'(bus_out), 32'hFF);
      #2 reset_l = 1'b1;
      repeat (6) tick();
      check("rs_held_req", 32'(req_io), 0);
      check("rs_held_rdy", 32'(bus_rdy), 1);
      bus_ior_l = 1'b1;
      repeat (4) tick();
      bus_ior_l = 1'b0;
      repeat (3) tick();
      check("rs_again_req", 32'(req_io), 1);
      check("rs_again_addr", 32'(req_addr), 5);
      req_ack = 1'b1; rd_data = 8'h77;
      tick();
      req_ack = 1'b0;
      check("rs_again_out", 32'(bus_out), 32'h77);
      bus_ior_l = 1'b1;
      repeat (3) tick();
      check_idle("rs_end");

      // Two strobes falling together at an address both decoders would accept.
      bus_a = 20'hB03B0; tick();
      bus_ior_l = 1'b0; bus_memr_l = 1'b0;
      repeat (5) tick();
      check("sim_req", 32'({req_io, req_mem}), 0);
      check("sim_rdy", 32'(bus_rdy), 1);
      bus_ior_l = 1'b1; bus_memr_l = 1'b1;
      repeat (3) tick();

      // Randomized cycles.
      for (int n = 0; n < 16; n++) begin
         int          s, kind;
         logic [19:0] a;
         logic        aen;
         s    = int'($urandom_range(0, 3));
         kind = int'($urandom_range(0, 2));
         a    = 20'($urandom);
         if (kind != 2) begin
            if (s < 2) a[11:4] = 8'h3B;
            else       a[19:15] = 5'b10110;
         end
         aen = ($urandom_range(0, 3) == 0);
         run_cycle($sformatf("rnd%0d", n), s, a, aen, 8'($urandom),
                   int'($urandom_range(0, 12)), 8'($urandom));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
